bus_master_if: RTL and testbench

BUS_MASTER_IF -- requirements
Module: bus_master_if

---
 rtl/bus_master_if.sv | 158 +++++++++++++++
 tb/tb_bus_master_if.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_if.sv
// bus_master_if: single-outstanding bus master that stalls the core while it requests, strobes and waits on a shared bus.
// Define BUS_MASTER_TIMEOUT_EN to abort accesses whose slave never answers; the default build waits indefinitely.
module bus_master_if (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  output logic [31:0] cpu_rd_data,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        bus_req_n,
  input  logic        bus_grnt_n,
  output logic [29:0] bus_addr,
  output logic        bus_as_n,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_n
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cpu_rd_data_q, cpu_rd_data_d;
  logic        cpu_busy_q, cpu_busy_d;
  logic        cpu_done_q, cpu_done_d;
  logic        bus_req_n_q, bus_req_n_d;
  logic        bus_as_n_q, bus_as_n_d;
  logic        bus_rw_q, bus_rw_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wr_data_q, bus_wr_data_d;
  logic        in_access;
  logic        rdy;
  logic        timeout;

  assign in_access = (state_q == ACCESS) || (state_q == WAIT);
  assign rdy       = in_access && !bus_rdy_n;

`ifdef BUS_MASTER_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       cpu_err_q, cpu_err_d;

  // A ready slave always wins over an expiring counter in the same cycle.
  assign timeout   = in_access && bus_rdy_n && (tmo_cnt_q == 8'd255);
  assign cpu_err_d = timeout;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == REQ) && !bus_grnt_n) begin
      tmo_cnt_d = 8'd0;
    end else if (in_access && bus_rdy_n && (tmo_cnt_q != 8'd255)) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= 8'd0;
      cpu_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      cpu_err_q <= cpu_err_d;
    end
  end

  assign cpu_err = cpu_err_q;
`else
  assign timeout = 1'b0;
  assign cpu_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rw_q          <= 1'b1;
      wdata_q       <= '0;
      cpu_rd_data_q <= '0;
      cpu_busy_q    <= 1'b0;
      cpu_done_q    <= 1'b0;
      bus_req_n_q   <= 1'b1;
      bus_as_n_q    <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rw_q          <= rw_d;
      wdata_q       <= wdata_d;
      cpu_rd_data_q <= cpu_rd_data_d;
      cpu_busy_q    <= cpu_busy_d;
      cpu_done_q    <= cpu_done_d;
      bus_req_n_q   <= bus_req_n_d;
      bus_as_n_q    <= bus_as_n_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
    end
  end

  // Completion always lands in IDLE, so a request held through cpu_done is only taken one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (cpu_req) state_d = REQ;
      REQ:         if (!bus_grnt_n) state_d = ACCESS;
      ACCESS, WAIT: begin
        if (rdy || timeout) state_d = IDLE;
        else                state_d = WAIT;
      end
      default:     state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    addr_d        = addr_q;
    rw_d          = rw_q;
    wdata_d       = wdata_q;
    if ((state_q == IDLE) && cpu_req) begin
      addr_d  = cpu_addr;
      rw_d    = cpu_rw;
      wdata_d = cpu_wr_data;
    end

    cpu_busy_d    = (state_d != IDLE);
    bus_req_n_d   = (state_d == IDLE);
    bus_as_n_d    = (state_d != ACCESS);
    cpu_done_d    = in_access && (rdy || timeout);
    cpu_rd_data_d = (rdy && rw_q) ? bus_rd_data : cpu_rd_data_q;

    bus_addr_d    = '0;
    bus_rw_d      = 1'b1;
    bus_wr_data_d = '0;
    if ((state_d == ACCESS) || (state_d == WAIT)) begin
      bus_addr_d    = addr_q;
      bus_rw_d      = rw_q;
      bus_wr_data_d = wdata_q;
    end
  end

  assign cpu_rd_data = cpu_rd_data_q;
  assign cpu_busy    = cpu_busy_q;
  assign cpu_done    = cpu_done_q;
  assign bus_req_n   = bus_req_n_q;
  assign bus_as_n    = bus_as_n_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: randomized scoreboard bench for bus_master_if with a reactive arbiter/slave model.
// Honours BUS_MASTER_TIMEOUT_EN the same way as the design.
module tb_bus_master_if;

  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [29:0] cpu_addr = '0;
  logic [31:0] cpu_wr_data = '0;
  logic [31:0] cpu_rd_data;
  logic        cpu_busy, cpu_done, cpu_err;
  logic        bus_req_n;
  logic        bus_grnt_n = 1'b1;
  logic [29:0] bus_addr;
  logic        bus_as_n, bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data = '0;
  logic        bus_rdy_n = 1'b1;

  bus_master_if dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_rd_data(cpu_rd_data), .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .bus_req_n(bus_req_n), .bus_grnt_n(bus_grnt_n), .bus_addr(bus_addr), .bus_as_n(bus_as_n),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_n(bus_rdy_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;
    int          req_cycles;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          done_cyc;
  } rsp_exp_t;

  bus_exp_t    bus_q[$];
  rsp_exp_t    rsp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rd = '0;

  int          grant_delay = 0;
  int          rdy_delay = 0;
  logic [31:0] slave_data = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Arbiter and slave: grant after grant_delay REQ cycles, ready rdy_delay cycles after the strobe,
  // random noise on grant/ready/data whenever the master must be ignoring them.
  initial begin
    bit in_access = 0;
    int req_cnt = 0;
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset || bus_req_n) begin
        in_access   = 0;
        req_cnt     = 0;
        bus_grnt_n  = 1'b1;
        bus_rdy_n   = 1'($urandom);
        bus_rd_data = $urandom;
      end else if (!in_access && bus_as_n) begin
        bus_grnt_n  = (req_cnt >= grant_delay) ? 1'b0 : 1'b1;
        req_cnt++;
        bus_rdy_n   = 1'($urandom);
        bus_rd_data = $urandom;
      end else begin
        if (!bus_as_n) begin
          in_access = 1;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
        bus_grnt_n = 1'($urandom);
        bus_rdy_n  = (wait_cnt >= rdy_delay) ? 1'b0 : 1'b1;
        bus_rd_data = bus_rdy_n ? $urandom : slave_data;
      end
    end
  end

  // Monitor: checks each strobe and each completion against the queued expectations.
  initial begin
    bit          strobe_seen = 0;
    bit          hold_bad = 0;
    int          as_cnt = 0;
    int          req_cycles = 0;
    logic [29:0] h_addr = '0;
    logic        h_rw = 1'b0;
    logic [31:0] h_wd = '0;
    bus_exp_t    be;
    rsp_exp_t    re;
    forever begin
      @(negedge clk);
      if (!reset) begin
        strobe_seen = 0; hold_bad = 0; as_cnt = 0; req_cycles = 0;
      end else begin
        if (cpu_busy && !strobe_seen && bus_as_n && !bus_req_n) req_cycles++;
        if (!bus_as_n) begin
          as_cnt++;
          if (!strobe_seen) begin
            strobe_seen = 1;
            h_addr = bus_addr; h_rw = bus_rw; h_wd = bus_wr_data;
            if (bus_q.size() == 0) begin
              checkOutput("unexpected strobe", 1, 0);
            end else begin
              be = bus_q.pop_front();
              checkOutput("strobe addr", 64'(bus_addr), 64'(be.addr));
              checkOutput("strobe rw", 64'(bus_rw), 64'(be.rw));
              checkOutput("strobe wdata", 64'(bus_wr_data), 64'(be.wdata));
              checkOutput("req phase cycles", 64'(req_cycles), 64'(be.req_cycles));
            end
          end
        end else if (strobe_seen && cpu_busy) begin
          if (bus_addr !== h_addr || bus_rw !== h_rw || bus_wr_data !== h_wd || bus_req_n !== 1'b0)
            hold_bad = 1;
        end
        if (cpu_done) begin
          if (rsp_q.size() == 0) begin
            checkOutput("spurious done", 1, 0);
          end else begin
            re = rsp_q.pop_front();
            checkOutput("done rd_data", 64'(cpu_rd_data), 64'(re.rd));
            checkOutput("done err", 64'(cpu_err), 64'(re.err));
            checkOutput("done cycle", 64'(cyc), 64'(re.done_cyc));
            checkOutput("strobe count", 64'(as_cnt), 64'd1);
            checkOutput("bus hold", 64'(hold_bad), 64'd0);
            checkOutput("done busy", 64'(cpu_busy), 64'd0);
            checkOutput("done req_n", 64'(bus_req_n), 64'd1);
            checkOutput("idle addr", 64'(bus_addr), 64'd0);
          end
          strobe_seen = 0; hold_bad = 0; as_cnt = 0; req_cycles = 0;
        end
      end
    end
  end

  // Call at a negedge: presents the request and queues what the access must produce.
  task automatic startAccess(input logic rw, input logic [29:0] addr, input logic [31:0] wd,
                             input int gd, input int rd, input logic [31:0] sd,
                             input bit push_rsp, input bit drop_req);
    bus_exp_t be;
    rsp_exp_t re;
    int       reff;
    bit       to;
    grant_delay = gd; rdy_delay = rd; slave_data = sd;
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wr_data = wd;
    be.rw = rw; be.addr = addr; be.wdata = wd; be.req_cycles = gd + 1;
    bus_q.push_back(be);
`ifdef BUS_MASTER_TIMEOUT_EN
    to   = (rd > 255);
    reff = to ? 255 : rd;
`else
    to   = 0;
    reff = rd;
`endif
    re.err      = to;
    re.rd       = (rw && !to) ? sd : model_rd;
    re.done_cyc = cyc + 3 + gd + reff;
    if (rw && !to) model_rd = sd;
    if (push_rsp) rsp_q.push_back(re);
    if (drop_req) begin
      @(negedge clk);
      cpu_req = 1'b0; cpu_rw = 1'($urandom); cpu_addr = 30'($urandom); cpu_wr_data = $urandom;
    end
  endtask

  task automatic waitDone(input int budget);
    bit seen = 0;
    for (int k = 0; k < budget; k++) begin
      if (cpu_done === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("done within budget", 64'(seen), 64'd1);
  endtask

  task automatic applyStimulus(input logic rw, input logic [29:0] addr, input logic [31:0] wd,
                               input int gd, input int rd, input logic [31:0] sd);
    @(negedge clk);
    startAccess(rw, addr, wd, gd, rd, sd, 1, 1);
    waitDone(gd + ((rd > 300) ? 300 : rd) + 40);
    @(negedge clk);
    checkOutput("done pulse width", 64'(cpu_done), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " busy"}, 64'(cpu_busy), 64'd0);
    checkOutput({tag, " done"}, 64'(cpu_done), 64'd0);
    checkOutput({tag, " err"}, 64'(cpu_err), 64'd0);
    checkOutput({tag, " req_n"}, 64'(bus_req_n), 64'd1);
    checkOutput({tag, " as_n"}, 64'(bus_as_n), 64'd1);
    checkOutput({tag, " bus_rw"}, 64'(bus_rw), 64'd1);
    checkOutput({tag, " bus_addr"}, 64'(bus_addr), 64'd0);
    checkOutput({tag, " bus_wr_data"}, 64'(bus_wr_data), 64'd0);
    checkOutput({tag, " rd_data"}, 64'(cpu_rd_data), 64'd0);
  endtask

  initial begin
    int  stall;
    bit  stall_bad;
    repeat (3) @(negedge clk);
    checkResetValues("por");
    reset = 1'b1;

    $display("[TB] zero-wait read and write with delays");
    applyStimulus(1'b1, 30'h0000_0040, 32'h0, 0, 0, 32'h5678);
    applyStimulus(1'b0, 30'h1000_0000, 32'h1234, 2, 2, 32'hDEAD_BEEF);
    $display("[TB] grant withheld");
    applyStimulus(1'b1, 30'h0ABC_DEF0, 32'h1, 10, 1, 32'hCAFE_F00D);

    $display("[TB] back-to-back reads with request held");
    @(negedge clk);
    startAccess(1'b1, 30'h0000_0100, 32'h0, 0, 1, 32'h1111_2222, 1, 0);
    waitDone(20);
    startAccess(1'b1, 30'h0000_0200, 32'h0, 0, 0, 32'h3333_4444, 1, 1);
    checkOutput("b2b req_n low again", 64'(bus_req_n), 64'd0);
    checkOutput("b2b busy again", 64'(cpu_busy), 64'd1);
    waitDone(20);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 25; i++)
      applyStimulus(1'($urandom), 30'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 5), $urandom);

`ifdef BUS_MASTER_TIMEOUT_EN
    $display("[TB] ready on the last allowed cycle, then a slave that never answers");
    applyStimulus(1'b1, 30'h0000_0300, 32'h0, 0, 255, 32'h7777_8888);
    applyStimulus(1'b1, 30'h0000_0304, 32'h0, 1, NEVER, 32'h9999_AAAA);
    stall = 30;
`else
    stall = 400;
`endif

    $display("[TB] unanswered access then reset mid-wait");
    @(negedge clk);
    startAccess(1'b1, 30'h0000_0400, 32'h5555, 1, NEVER, 32'hBBBB_CCCC, 0, 1);
    stall_bad = 0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (cpu_done !== 1'b0 || cpu_busy !== 1'b1) stall_bad = 1;
    end
    checkOutput("stalled in wait", 64'(stall_bad), 64'd0);
    #2 reset = 1'b0;
    #1 checkResetValues("async");
    bus_q.delete(); rsp_q.delete(); model_rd = '0;
    repeat (3) @(negedge clk);
    checkOutput("no done in reset", 64'(cpu_done), 64'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 30'h0000_0500, 32'h0, 0, 0, 32'hA5A5_5A5A);

    repeat (5) @(negedge clk);
    checkOutput("queues drained", 64'(bus_q.size() + rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: actual running required finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
